// File: rtl/fifo_to_mem_mc.sv
// Round-robin drain of NUM_CH FWFT FIFOs into a contiguous memory window via a ready/valid write port.
// Ring (wrap-around) mode is compiled in only when FIFO_TO_MEM_MC_WRAP_EN is defined.
module fifo_to_mem_mc #(
    parameter int          FIFO_DATA_WIDTH = 144,
    parameter int          MEM_ADDR_WIDTH  = 19,
    parameter int          MEM_DATA_WIDTH  = 144,
    parameter int          NUM_CH          = 4,
    parameter int          CNT_WIDTH       = 32,
    parameter int unsigned MEM_ADDR_LOW    = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sw_rst,
    input  logic                                cal_done,
    input  logic                                start_store,
    input  logic                                wrap_mode,
    output logic [NUM_CH-1:0]                   fifo_rd_en,
    input  logic [NUM_CH*FIFO_DATA_WIDTH-1:0]   fifo_data,
    input  logic [NUM_CH-1:0]                   fifo_empty,
    output logic                                app_wr_cmd,
    input  logic                                app_wr_rdy,
    output logic [MEM_ADDR_WIDTH-1:0]           app_wr_addr,
    output logic [MEM_DATA_WIDTH-1:0]           app_wr_data,
    input  logic [MEM_ADDR_WIDTH-1:0]           dflow_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]           dflow_addr_high,
    output logic [MEM_ADDR_WIDTH-1:0]           dflow_mem_high,
    output logic                                complete_store,
    output logic [CNT_WIDTH-1:0]                wr_count,
    output logic [CNT_WIDTH-1:0]                wrap_count,
    output logic [2:0]                          dbg_state
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RUN        = 3'd1;
    localparam logic [2:0] S_DRAIN      = 3'd2;
    localparam logic [2:0] S_DRAIN_DONE = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]                 r_state;
    logic [MEM_ADDR_WIDTH-1:0]  r_lo;
    logic [MEM_ADDR_WIDTH-1:0]  r_hi;
    logic [MEM_ADDR_WIDTH-1:0]  r_ptr;
    logic [MEM_ADDR_WIDTH-1:0]  r_addr;
    logic [MEM_ADDR_WIDTH-1:0]  r_mem_high;
    logic [MEM_DATA_WIDTH-1:0]  r_data;
    logic                       r_cmd;
    logic                       r_complete;
    logic [CNT_WIDTH-1:0]       r_wr_count;
    logic [CH_W-1:0]            r_last;

    logic [CH_W-1:0]            w_grant;
    logic [CH_W:0]              w_sum;
    logic                       w_any;
    logic                       w_rst;
    logic                       w_slot_free;
    logic                       w_pop;
    logic                       w_accept;
    logic                       w_last_addr;
    logic                       w_wrap_en;
    logic [FIFO_DATA_WIDTH-1:0] w_word;

`ifdef FIFO_TO_MEM_MC_WRAP_EN
    logic [CNT_WIDTH-1:0]       r_wrap_count;
    assign w_wrap_en  = wrap_mode;
    assign wrap_count = r_wrap_count;
`else
    logic                       w_unused_wrap_mode;
    assign w_unused_wrap_mode = wrap_mode;
    assign w_wrap_en  = 1'b0;
    assign wrap_count = '0;
`endif

    // Search starts one past the last grant so every non-empty channel is served in turn.
    always_comb begin
        w_grant = r_last;
        w_any   = 1'b0;
        w_sum   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_sum = {1'b0, r_last} + (CH_W+1)'(i);
            if (w_sum >= (CH_W+1)'(NUM_CH)) begin
                w_sum = w_sum - (CH_W+1)'(NUM_CH);
            end
            if (!w_any && !fifo_empty[w_sum[CH_W-1:0]]) begin
                w_any   = 1'b1;
                w_grant = w_sum[CH_W-1:0];
            end
        end
    end

    // app_wr_cmd/app_wr_rdy: a write transfers on every cycle both are high; while cmd is
    // high and rdy low the address and data stay frozen and no new word is popped.
    assign w_rst       = rst | sw_rst;
    assign w_slot_free = ~r_cmd | app_wr_rdy;
    assign w_pop       = ~w_rst & (r_state == S_RUN) & start_store & cal_done & w_slot_free & w_any;
    assign w_accept    = r_cmd & app_wr_rdy;
    assign w_last_addr = (r_ptr == r_hi - MEM_ADDR_WIDTH'(1));
    assign w_word      = fifo_data[int'(w_grant)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];

    always_comb begin
        fifo_rd_en = '0;
        if (w_pop) begin
            fifo_rd_en[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state      <= S_IDLE;
            r_lo         <= '0;
            r_hi         <= '0;
            r_ptr        <= '0;
            r_addr       <= MEM_ADDR_WIDTH'(MEM_ADDR_LOW);
            r_mem_high   <= '0;
            r_data       <= '0;
            r_cmd        <= 1'b0;
            r_complete   <= 1'b0;
            r_wr_count   <= '0;
            r_last       <= CH_W'(NUM_CH - 1);
`ifdef FIFO_TO_MEM_MC_WRAP_EN
            r_wrap_count <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_mem_high <= r_addr;
                if (r_wr_count != '1) begin
                    r_wr_count <= r_wr_count + CNT_WIDTH'(1);
                end
                if (!w_pop) begin
                    r_cmd <= 1'b0;
                end
            end

            if (w_pop) begin
                r_cmd  <= 1'b1;
                r_addr <= r_ptr;
                r_data <= MEM_DATA_WIDTH'(w_word);
                r_last <= w_grant;
                if (w_last_addr) begin
                    if (w_wrap_en) begin
                        r_ptr <= r_lo;
`ifdef FIFO_TO_MEM_MC_WRAP_EN
                        if (r_wrap_count != '1) begin
                            r_wrap_count <= r_wrap_count + CNT_WIDTH'(1);
                        end
`endif
                    end
                end else begin
                    r_ptr <= r_ptr + MEM_ADDR_WIDTH'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start_store) begin
                        r_lo       <= dflow_addr_low;
                        r_hi       <= dflow_addr_high;
                        r_ptr      <= dflow_addr_low;
                        r_wr_count <= '0;
                        r_complete <= 1'b0;
`ifdef FIFO_TO_MEM_MC_WRAP_EN
                        r_wrap_count <= '0;
`endif
                        // An empty or inverted window completes without touching memory.
                        if (dflow_addr_low >= dflow_addr_high) begin
                            r_state    <= S_DONE;
                            r_complete <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!start_store) begin
                        r_state <= S_DRAIN;
                    end else if (w_pop && w_last_addr && !w_wrap_en) begin
                        r_state <= S_DRAIN_DONE;
                    end
                end
                S_DRAIN: begin
                    if (w_slot_free) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN_DONE: begin
                    if (w_slot_free) begin
                        r_state    <= S_DONE;
                        r_complete <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start_store) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign app_wr_cmd     = r_cmd;
    assign app_wr_addr    = r_addr;
    assign app_wr_data    = r_data;
    assign dflow_mem_high = r_mem_high;
    assign complete_store = r_complete;
    assign wr_count       = r_wr_count;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_fifo_to_mem_mc.sv
// Bench for fifo_to_mem_mc: FWFT FIFO models feed the DUT, expected writes are queued when
// words are loaded and compared as the write port accepts them.
module tb_fifo_to_mem_mc;

    localparam int FDW = 144;
    localparam int MAW = 19;
    localparam int MDW = 144;
    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int EW  = MAW + MDW;

    logic               clk = 1'b0;
    logic               rst;
    logic               sw_rst;
    logic               cal_done;
    logic               start_store;
    logic               wrap_mode;
    logic [NCH-1:0]     fifo_rd_en;
    logic [NCH*FDW-1:0] fifo_data;
    logic [NCH-1:0]     fifo_empty;
    logic               app_wr_cmd;
    logic               app_wr_rdy;
    logic [MAW-1:0]     app_wr_addr;
    logic [MDW-1:0]     app_wr_data;
    logic [MAW-1:0]     dflow_addr_low;
    logic [MAW-1:0]     dflow_addr_high;
    logic [MAW-1:0]     dflow_mem_high;
    logic               complete_store;
    logic [CW-1:0]      wr_count;
    logic [CW-1:0]      wrap_count;
    logic [2:0]         dbg_state;

    fifo_to_mem_mc #(
        .FIFO_DATA_WIDTH(FDW),
        .MEM_ADDR_WIDTH (MAW),
        .MEM_DATA_WIDTH (MDW),
        .NUM_CH         (NCH),
        .CNT_WIDTH      (CW),
        .MEM_ADDR_LOW   (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_rst         (sw_rst),
        .cal_done       (cal_done),
        .start_store    (start_store),
        .wrap_mode      (wrap_mode),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .app_wr_cmd     (app_wr_cmd),
        .app_wr_rdy     (app_wr_rdy),
        .app_wr_addr    (app_wr_addr),
        .app_wr_data    (app_wr_data),
        .dflow_addr_low (dflow_addr_low),
        .dflow_addr_high(dflow_addr_high),
        .dflow_mem_high (dflow_mem_high),
        .complete_store (complete_store),
        .wr_count       (wr_count),
        .wrap_count     (wrap_count),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- state ----------------
    logic [FDW-1:0] fq [NCH][$];
    logic [EW-1:0]  exp_q [$];
    int             exp_left [NCH];
    int             n_tests = 0;
    int             n_fail  = 0;
    logic [NCH-1:0] pend_pop = '0;
    logic           prev_stall = 1'b0;
    logic [MAW-1:0] prev_addr;
    logic [MDW-1:0] prev_data;
    logic           pat [4];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- FIFO models ----------------
    task automatic refresh_fifos();
        for (int c = 0; c < NCH; c++) begin
            fifo_empty[c] = (fq[c].size() == 0);
            fifo_data[c*FDW +: FDW] = (fq[c].size() != 0) ? fq[c][0] : '0;
        end
    endtask

    task automatic load(input int ch, input int n);
        logic [FDW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = '0;
            for (int j = 0; j < 5; j++) begin
                w = {w[FDW-33:0], $urandom()};
            end
            fq[ch].push_back(w);
        end
        refresh_fifos();
    endtask

    // Round-robin reference order over the loaded words; arbiter starts with last grant NCH-1.
    task automatic build_expected(input logic [MAW-1:0] lo, input logic [MAW-1:0] hi,
                                  input logic wrap, output int n_exp, output int n_wrap);
        int             taken [NCH];
        int             last;
        int             g;
        logic [MAW-1:0] ptr;
        logic           done;
        n_exp  = 0;
        n_wrap = 0;
        last   = NCH - 1;
        ptr    = lo;
        done   = (lo >= hi);
        for (int c = 0; c < NCH; c++) taken[c] = 0;
        while (!done) begin
            g = -1;
            for (int i = 1; i <= NCH; i++) begin
                int c = (last + i) % NCH;
                if (g < 0 && taken[c] < fq[c].size()) g = c;
            end
            if (g < 0) begin
                done = 1'b1;
            end else begin
                exp_q.push_back({ptr, MDW'(fq[g][taken[g]])});
                taken[g]++;
                last = g;
                n_exp++;
                if (ptr == hi - MAW'(1)) begin
                    if (wrap) begin
                        ptr = lo;
                        n_wrap++;
                    end else begin
                        done = 1'b1;
                    end
                end else begin
                    ptr = ptr + MAW'(1);
                end
            end
        end
        for (int c = 0; c < NCH; c++) exp_left[c] = fq[c].size() - taken[c];
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst || sw_rst) begin
            prev_stall = 1'b0;
            pend_pop   = '0;
        end else begin
            pend_pop = fifo_rd_en;
            if (prev_stall) begin
                check("hold_cmd",  256'(app_wr_cmd), 256'(1));
                check("hold_addr", 256'(app_wr_addr), 256'(prev_addr));
                check("hold_data", 256'(app_wr_data), 256'(prev_data));
            end
            if (app_wr_cmd && !app_wr_rdy) begin
                check("pop_while_stalled", 256'(fifo_rd_en), 256'(0));
            end
            if (app_wr_cmd && app_wr_rdy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 256'(app_wr_cmd), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 256'(app_wr_addr), 256'(e[EW-1:MDW]));
                    check("wr_data", 256'(app_wr_data), 256'(e[MDW-1:0]));
                end
            end
            prev_stall = app_wr_cmd && !app_wr_rdy;
            prev_addr  = app_wr_addr;
            prev_data  = app_wr_data;
        end
    end

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NCH; c++) begin
            if (pend_pop[c] && fq[c].size() != 0) void'(fq[c].pop_front());
        end
        pend_pop = '0;
        refresh_fifos();
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        sw_rst      = 1'b0;
        start_store = 1'b0;
        wrap_mode   = 1'b0;
        cal_done    = 1'b1;
        app_wr_rdy  = 1'b1;
        for (int c = 0; c < NCH; c++) fq[c].delete();
        exp_q.delete();
        refresh_fifos();
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic set_window(input logic [MAW-1:0] lo, input logic [MAW-1:0] hi);
        dflow_addr_low  = lo;
        dflow_addr_high = hi;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (exp_q.size() == 0) break;
        end
        check(tag, 256'(exp_q.size()), 256'(0));
    endtask

    task automatic stop_run();
        start_store = 1'b0;
        app_wr_rdy  = 1'b1;
        repeat (4) step();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rd_en"},     256'(fifo_rd_en),     256'(0));
        check({pfx, "_cmd"},       256'(app_wr_cmd),     256'(0));
        check({pfx, "_addr"},      256'(app_wr_addr),    256'(0));
        check({pfx, "_data"},      256'(app_wr_data),    256'(0));
        check({pfx, "_mem_high"},  256'(dflow_mem_high), 256'(0));
        check({pfx, "_complete"},  256'(complete_store), 256'(0));
        check({pfx, "_wr_count"},  256'(wr_count),       256'(0));
        check({pfx, "_wrap_cnt"},  256'(wrap_count),     256'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   n_exp;
        int   n_wrap;
        int   n_win;
        logic wrap_en;
        logic exp_c;
        logic [MAW-1:0] lo;
        logic [MAW-1:0] hi;

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        rst = 1'b1; sw_rst = 1'b0; cal_done = 1'b1; start_store = 1'b0;
        wrap_mode = 1'b0; app_wr_rdy = 1'b1;
        set_window('0, '0);
        refresh_fifos();
        reset_dut();
        check_reset_outputs("rst");

        // 3 words per channel, roomy window: channel order 0,1,2,3,... at 0x10..0x1B
        reset_dut();
        for (int c = 0; c < NCH; c++) load(c, 3);
        set_window(MAW'(16), MAW'(32));
        build_expected(MAW'(16), MAW'(32), 1'b0, n_exp, n_wrap);
        start_store = 1'b1;
        wait_done("t1_all_written", 200);
        repeat (3) step();
        check("t1_wr_count", 256'(wr_count), 256'(12));
        check("t1_complete", 256'(complete_store), 256'(0));
        check("t1_mem_high", 256'(dflow_mem_high), 256'(27));
        for (int c = 0; c < NCH; c++) check("t1_left", 256'(fq[c].size()), 256'(0));
        stop_run();

        // single pass, window of 4, 8 words on ch2
        reset_dut();
        load(2, 8);
        set_window(MAW'(16), MAW'(20));
        build_expected(MAW'(16), MAW'(20), 1'b0, n_exp, n_wrap);
        start_store = 1'b1;
        wait_done("t2_all_written", 200);
        check("t2_complete_edge", 256'(complete_store), 256'(1));
        repeat (3) step();
        check("t2_mem_high", 256'(dflow_mem_high), 256'(19));
        check("t2_wr_count", 256'(wr_count), 256'(4));
        check("t2_left_ch2", 256'(fq[2].size()), 256'(4));
        check("t2_complete", 256'(complete_store), 256'(1));
        stop_run();

        // ready pattern 1,0,0,1 repeating
        reset_dut();
        for (int c = 0; c < NCH; c++) load(c, 2);
        set_window(MAW'(64), MAW'(128));
        build_expected(MAW'(64), MAW'(128), 1'b0, n_exp, n_wrap);
        start_store = 1'b1;
        for (int i = 0; i < 200; i++) begin
            app_wr_rdy = pat[i % 4];
            step();
            if (exp_q.size() == 0) break;
        end
        check("t3_all_written", 256'(exp_q.size()), 256'(0));
        app_wr_rdy = 1'b1;
        repeat (3) step();
        check("t3_wr_count", 256'(wr_count), 256'(8));
        stop_run();

        // ring mode: window [0,4), 10 words
        reset_dut();
`ifdef FIFO_TO_MEM_MC_WRAP_EN
        wrap_en = 1'b1;
`else
        wrap_en = 1'b0;
`endif
        exp_c = ~wrap_en;
        wrap_mode = 1'b1;
        load(1, 10);
        set_window(MAW'(0), MAW'(4));
        build_expected(MAW'(0), MAW'(4), wrap_en, n_exp, n_wrap);
        start_store = 1'b1;
        wait_done("t4_all_written", 200);
        repeat (3) step();
        check("t4_wrap_count", 256'(wrap_count), 256'(n_wrap));
        check("t4_wr_count", 256'(wr_count), 256'(n_exp));
        check("t4_complete", 256'(complete_store), 256'(exp_c));
        stop_run();

        // stop while a write is stalled
        reset_dut();
        app_wr_rdy = 1'b0;
        load(0, 4);
        set_window(MAW'(0), MAW'(16));
        exp_q.push_back({MAW'(0), MDW'(fq[0][0])});
        start_store = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (app_wr_cmd) break;
        end
        check("t5_cmd_up", 256'(app_wr_cmd), 256'(1));
        start_store = 1'b0;
        repeat (3) step();
        check("t5_cmd_held", 256'(app_wr_cmd), 256'(1));
        check("t5_addr_held", 256'(app_wr_addr), 256'(0));
        app_wr_rdy = 1'b1;
        repeat (6) step();
        check("t5_written", 256'(exp_q.size()), 256'(0));
        check("t5_left_ch0", 256'(fq[0].size()), 256'(3));
        check("t5_wr_count", 256'(wr_count), 256'(1));
        check("t5_cmd_low", 256'(app_wr_cmd), 256'(0));

        // software reset mid-run
        reset_dut();
        for (int c = 0; c < NCH; c++) load(c, 4);
        set_window(MAW'(0), MAW'(64));
        build_expected(MAW'(0), MAW'(64), 1'b0, n_exp, n_wrap);
        start_store = 1'b1;
        repeat (5) step();
        check("t6_streaming", 256'(app_wr_cmd), 256'(1));
        sw_rst = 1'b1;
        start_store = 1'b0;
        @(negedge clk);
        check("t6_no_pop_in_rst", 256'(fifo_rd_en), 256'(0));
        @(posedge clk);
        #1;
        sw_rst = 1'b0;
        check_reset_outputs("swrst");
        exp_q.delete();
        repeat (2) step();

        // empty window completes at once
        reset_dut();
        load(3, 2);
        set_window(MAW'(32), MAW'(32));
        start_store = 1'b1;
        step();
        check("t7_complete", 256'(complete_store), 256'(1));
        repeat (4) step();
        check("t7_left_ch3", 256'(fq[3].size()), 256'(2));
        check("t7_wr_count", 256'(wr_count), 256'(0));
        check("t7_cmd", 256'(app_wr_cmd), 256'(0));
        stop_run();

        // random loads, windows, ready and calibration
        for (int it = 0; it < 6; it++) begin
            reset_dut();
            for (int c = 0; c < NCH; c++) load(c, int'($urandom_range(0, 6)));
            lo = MAW'($urandom_range(0, 200));
            hi = lo + MAW'($urandom_range(1, 24));
            n_win = int'(hi) - int'(lo);
            set_window(lo, hi);
            build_expected(lo, hi, 1'b0, n_exp, n_wrap);
            start_store = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                app_wr_rdy = 1'($urandom_range(0, 1));
                cal_done   = ($urandom_range(0, 3) != 0);
                step();
                if (exp_q.size() == 0) break;
            end
            check("t8_all_written", 256'(exp_q.size()), 256'(0));
            app_wr_rdy = 1'b1;
            cal_done   = 1'b1;
            repeat (3) step();
            check("t8_wr_count", 256'(wr_count), 256'(n_exp));
            check("t8_complete", 256'(complete_store), 256'(n_exp == n_win));
            for (int c = 0; c < NCH; c++) check("t8_left", 256'(fq[c].size()), 256'(exp_left[c]));
            stop_run();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
